// File: rtl/rv32_dbg_pkg.sv
// Shared definitions for the RV32I run/step/load controller.
//   run_state_e  : controller state encoding (also visible on the state output)
//   halt_cause_e : reason the core was last halted
//   EBREAK_INSN  : RV32I EBREAK encoding, used to stop a free run
package rv32_dbg_pkg;

    typedef enum logic [2:0] {
        StRstSeq = 3'd0,
        StHalt   = 3'd1,
        StLoad   = 3'd2,
        StRun    = 3'd3,
        StStep   = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        CauseNone   = 2'd0,
        CauseCmd    = 2'd1,
        CauseBp     = 2'd2,
        CauseEbreak = 2'd3
    } halt_cause_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/rv32_run_ctrl_if.sv
// Debug/core-side bundle of the run controller.
//   commands    : cmd_load/cmd_run/cmd_step/cmd_halt one-cycle pulses
//   load stream : ld_valid/ld_data/ld_last in, ld_ready out
//   breakpoint  : bp_en, bp_addr
//   core side   : pc, instr in; cpu_en, cpu_rst out
//   imem write  : imem_we, imem_waddr, imem_wdata out
//   status      : state, halt_cause, retired out
// slave is the controller's view, master the debug host / core view.
interface rv32_run_ctrl_if #(
    parameter int unsigned IMEM_AW = 10
) ();
    logic               cmd_load;
    logic               cmd_run;
    logic               cmd_step;
    logic               cmd_halt;
    logic               ld_valid;
    logic [31:0]        ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic               bp_en;
    logic [31:0]        bp_addr;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic               cpu_en;
    logic               cpu_rst;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic [2:0]         state;
    logic [1:0]         halt_cause;
    logic [31:0]        retired;

    modport slave (
        input  cmd_load, cmd_run, cmd_step, cmd_halt,
        input  ld_valid, ld_data, ld_last,
        input  bp_en, bp_addr, pc, instr,
        output ld_ready, cpu_en, cpu_rst,
        output imem_we, imem_waddr, imem_wdata,
        output state, halt_cause, retired
    );

    modport master (
        output cmd_load, cmd_run, cmd_step, cmd_halt,
        output ld_valid, ld_data, ld_last,
        output bp_en, bp_addr, pc, instr,
        input  ld_ready, cpu_en, cpu_rst,
        input  imem_we, imem_waddr, imem_wdata,
        input  state, halt_cause, retired
    );
endinterface

// File: rtl/rv32_bp_match.sv
// Combinational stop detector for a free run.
//   pc_i, instr_i    : core's current PC and the instruction at it
//   bp_en_i, bp_addr_i : PC breakpoint
//   skip_i           : suppress a stop on the first instruction after resume
//   stop_o           : do not execute this instruction, halt next cycle
//   cause_o          : halt cause to record when stop_o is set
module rv32_bp_match
    import rv32_dbg_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        bp_en_i,
    input  logic [31:0] bp_addr_i,
    input  logic        skip_i,
    output logic        stop_o,
    output halt_cause_e cause_o
);
    logic bp_hit;
    logic ebreak_hit;

    always_comb begin
        bp_hit     = bp_en_i && (pc_i == bp_addr_i);
        ebreak_hit = (instr_i == EBREAK_INSN);
        stop_o     = (bp_hit || ebreak_hit) && !skip_i;
        // EBREAK wins when both match
        cause_o    = ebreak_hit ? CauseEbreak : CauseBp;
    end
endmodule

// File: rtl/rv32_run_ctrl.sv
// Run/step/load controller for the single-cycle RV32I core.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : rv32_run_ctrl_if.slave (commands, load stream, breakpoint,
//              core enable/reset, imem write port, status)
// cpu_en, ld_ready and the imem write port are combinational; state, cpu_rst,
// halt_cause and retired are registered.
module rv32_run_ctrl
    import rv32_dbg_pkg::*;
#(
    parameter int unsigned IMEM_AW    = 10,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    rv32_run_ctrl_if.slave  bus
);
    localparam int unsigned CntW = ($clog2(RST_CYCLES) > 0) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CntW-1:0]    CntInit = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0]    CntOne  = CntW'(1);
    localparam logic [IMEM_AW-1:0] PtrMax  = '1;
    localparam logic [IMEM_AW-1:0] PtrOne  = IMEM_AW'(1);

    run_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IMEM_AW-1:0] ptr_q, ptr_d;
    logic               skip_q, skip_d;
    halt_cause_e        cause_q, cause_d;
    logic [31:0]        retired_q, retired_d;
    logic               cpu_rst_q, cpu_rst_d;

    logic        cpu_en;
    logic        accept;
    logic        stop;
    halt_cause_e stop_cause;

    rv32_bp_match u_bp_match (
        .pc_i      (bus.pc),
        .instr_i   (bus.instr),
        .bp_en_i   (bus.bp_en),
        .bp_addr_i (bus.bp_addr),
        .skip_i    (skip_q),
        .stop_o    (stop),
        .cause_o   (stop_cause)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        skip_d    = skip_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        cpu_en    = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StRstSeq: begin
                if (cnt_q == '0) begin
                    state_d = StHalt;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHalt: begin
                if (bus.cmd_halt) begin
                    state_d = StHalt;
                end else if (bus.cmd_load) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                end else if (bus.cmd_step) begin
                    state_d = StStep;
                    skip_d  = 1'b1;
                    cause_d = CauseNone;
                end else if (bus.cmd_run) begin
                    state_d = StRun;
                    skip_d  = 1'b1;
                    cause_d = CauseNone;
                end
            end
            StLoad: begin
                accept = bus.ld_valid;
                if (accept) begin
                    // pointer saturates at the top word; that accept ends the load
                    if (ptr_q != PtrMax) begin
                        ptr_d = ptr_q + PtrOne;
                    end
                    if (bus.ld_last || (ptr_q == PtrMax)) begin
                        state_d = StRstSeq;
                    end
                end
                if (bus.cmd_halt) begin
                    state_d = StRstSeq;
                end
            end
            StRun: begin
                cpu_en = !stop;
                if (cpu_en) begin
                    skip_d = 1'b0;
                end
                if (stop) begin
                    state_d = StHalt;
                    cause_d = stop_cause;
                end else if (bus.cmd_halt) begin
                    state_d = StHalt;
                    cause_d = CauseCmd;
                end else if (bus.cmd_load) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                end else if (bus.cmd_step) begin
                    state_d = StStep;
                    skip_d  = 1'b1;
                end
            end
            StStep: begin
                cpu_en  = 1'b1;
                skip_d  = 1'b1;
                state_d = StHalt;
                cause_d = CauseCmd;
            end
            default: begin
                state_d = StRstSeq;
            end
        endcase

        if ((state_d == StRstSeq) && (state_q != StRstSeq)) begin
            cnt_d     = CntInit;
            retired_d = '0;
        end else if (cpu_en) begin
            retired_d = retired_q + 32'd1;
        end

        cpu_rst_d = (state_d == StRstSeq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRstSeq;
            cnt_q     <= CntInit;
            ptr_q     <= '0;
            skip_q    <= 1'b0;
            cause_q   <= CauseNone;
            retired_q <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            skip_q    <= skip_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign bus.cpu_en     = cpu_en;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.ld_ready   = (state_q == StLoad);
    assign bus.imem_we    = accept;
    assign bus.imem_waddr = ptr_q;
    assign bus.imem_wdata = bus.ld_data;
    assign bus.state      = state_q;
    assign bus.halt_cause = cause_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_rv32_run_ctrl.sv
// Self-checking bench for rv32_run_ctrl: a tiny core model (PC advancing by 4
// on cpu_en, EBREAK at 0x20) plus a write scoreboard for the load stream.
module tb_rv32_run_ctrl;
    import rv32_dbg_pkg::*;

    localparam int unsigned IMEM_AW    = 10;
    localparam int unsigned RST_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32_run_ctrl_if #(.IMEM_AW(IMEM_AW)) ifc ();

    rv32_run_ctrl #(
        .IMEM_AW    (IMEM_AW),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    logic [IMEM_AW+31:0] wr_q [$];

    // core model
    logic [31:0] core_pc;
    always @(posedge clk) begin
        if (ifc.cpu_rst) core_pc <= 32'h0;
        else if (ifc.cpu_en) core_pc <= core_pc + 32'd4;
    end
    assign ifc.pc    = core_pc;
    assign ifc.instr = (core_pc == 32'h20) ? EBREAK_INSN : 32'h0000_0013;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // write monitor: every imem write must match the next expected entry
    always @(negedge clk) begin
        logic [IMEM_AW+31:0] exp;
        if (ifc.cpu_en === 1'b1) en_cnt++;
        if (ifc.imem_we === 1'b1) begin
            we_cnt++;
            if (wr_q.size() == 0) begin
                check_eq("imem_we_unexpected", 32'(ifc.imem_we), 32'd0);
            end else begin
                exp = wr_q.pop_front();
                check_eq("imem_waddr", 32'(ifc.imem_waddr), 32'(exp[IMEM_AW+31:32]));
                check_eq("imem_wdata", ifc.imem_wdata, exp[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic h, input logic l, input logic s, input logic r);
        ifc.cmd_halt = h;
        ifc.cmd_load = l;
        ifc.cmd_step = s;
        ifc.cmd_run  = r;
        tick();
        ifc.cmd_halt = 1'b0;
        ifc.cmd_load = 1'b0;
        ifc.cmd_step = 1'b0;
        ifc.cmd_run  = 1'b0;
    endtask

    task automatic send_word(input int addr, input logic [31:0] d, input logic last);
        ifc.ld_valid = 1'b1;
        ifc.ld_data  = d;
        ifc.ld_last  = last;
        wr_q.push_back({IMEM_AW'(addr), d});
        tick();
        ifc.ld_valid = 1'b0;
        ifc.ld_last  = 1'b0;
    endtask

    task automatic count_rst(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.cpu_rst === 1'b1) n++;
            else break;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (ifc.state !== s && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(ifc.state), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        ifc.cmd_load = 1'b0;
        ifc.cmd_run  = 1'b0;
        ifc.cmd_step = 1'b0;
        ifc.cmd_halt = 1'b0;
        ifc.ld_valid = 1'b0;
        ifc.ld_data  = 32'h0;
        ifc.ld_last  = 1'b0;
        ifc.bp_en    = 1'b0;
        ifc.bp_addr  = 32'h0;

        // reset sequence
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(ifc.state), 32'd0);
        check_eq("rst_cpu_rst", 32'(ifc.cpu_rst), 32'd1);
        check_eq("rst_cpu_en", 32'(ifc.cpu_en), 32'd0);
        check_eq("rst_ld_ready", 32'(ifc.ld_ready), 32'd0);
        check_eq("rst_cause", 32'(ifc.halt_cause), 32'd0);
        rst = 1'b0;
        count_rst(n);
        check_eq("rstseq_cycles", n, RST_CYCLES);
        check_eq("rstseq_to_halt", 32'(ifc.state), 32'd1);
        check_eq("halt_cpu_en", 32'(ifc.cpu_en), 32'd0);
        check_eq("halt_retired", ifc.retired, 32'd0);

        // load three words with a gap before the last
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("load_state", 32'(ifc.state), 32'd2);
        check_eq("load_ready", 32'(ifc.ld_ready), 32'd1);
        send_word(0, 32'hA5A5_0001, 1'b0);
        send_word(1, 32'hB00B_0002, 1'b0);
        tick();
        send_word(2, 32'hC0DE_0003, 1'b1);
        check_eq("load_end_rstseq", 32'(ifc.state), 32'd0);
        count_rst(n);
        check_eq("load_rst_cycles", n, RST_CYCLES);
        check_eq("load_then_halt", 32'(ifc.state), 32'd1);
        check_eq("load_we_count", we_cnt, 32'd3);
        check_eq("load_sb_empty", wr_q.size(), 32'd0);

        // three single steps
        tick();
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        check_eq("step_en_cycles", en_cnt, 32'd3);
        check_eq("step_retired", ifc.retired, 32'd3);
        check_eq("step_cause", 32'(ifc.halt_cause), 32'd1);
        check_eq("step_state", 32'(ifc.state), 32'd1);
        check_eq("step_pc", core_pc, 32'hC);

        // breakpoint at 0x10
        ifc.bp_en   = 1'b1;
        ifc.bp_addr = 32'h10;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_state(3'd1, "bp_halt_state");
        check_eq("bp_pc", core_pc, 32'h10);
        check_eq("bp_cause", 32'(ifc.halt_cause), 32'd2);
        check_eq("bp_retired", ifc.retired, 32'd4);

        // resume executes the breakpointed instruction, then run into EBREAK at 0x20
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("bp_resume_en", 32'(ifc.cpu_en), 32'd1);
        n = 0;
        while (core_pc != 32'h20 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("ebreak_pc", core_pc, 32'h20);
        check_eq("ebreak_en", 32'(ifc.cpu_en), 32'd0);
        check_eq("ebreak_still_run", 32'(ifc.state), 32'd3);
        tick();
        check_eq("ebreak_halt", 32'(ifc.state), 32'd1);
        check_eq("ebreak_cause", 32'(ifc.halt_cause), 32'd3);
        check_eq("ebreak_retired", ifc.retired, 32'd8);
        check_eq("ebreak_pc_held", core_pc, 32'h20);
        ifc.bp_en = 1'b0;

        // halt beats run
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("prio_state", 32'(ifc.state), 32'd1);
        @(negedge clk);
        check_eq("prio_cpu_en", 32'(ifc.cpu_en), 32'd0);

        // abort a load after two words
        tick();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        send_word(0, 32'hDEAD_0010, 1'b0);
        send_word(1, 32'hBEEF_0011, 1'b0);
        check_eq("abort_still_load", 32'(ifc.state), 32'd2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("abort_rstseq", 32'(ifc.state), 32'd0);
        wait_state(3'd1, "abort_halt");
        check_eq("abort_we_count", we_cnt, 32'd5);
        check_eq("abort_sb_empty", wr_q.size(), 32'd0);
        check_eq("abort_retired", ifc.retired, 32'd0);

        // asynchronous reset in the middle of a run
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("run_en_pre_reset", 32'(ifc.cpu_en), 32'd1);
        tick();
        check_eq("run_retired", ifc.retired, 32'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_en", 32'(ifc.cpu_en), 32'd0);
        check_eq("async_rst_state", 32'(ifc.state), 32'd0);
        check_eq("async_rst_cpu_rst", 32'(ifc.cpu_rst), 32'd1);
        check_eq("async_rst_retired", ifc.retired, 32'd0);
        tick();
        rst = 1'b0;
        count_rst(n);
        check_eq("post_rst_cycles", n, RST_CYCLES);
        check_eq("post_rst_halt", 32'(ifc.state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
